hamming_serial_rx: RTL and testbench
====================================

Name: hamming_serial_rx

Overview:
- Serial receiver and decoder for Hamming(12,8) codewords framed on a single-wire asynchronous line.
- Samples one frame: start bit, 12 codeword bits, stop bit. Computes the syndrome, corrects any single-bit error and presents the recovered byte on a valid/ready output port.
- Sits at the far end of the byte encoder and serializer link, between the line input pin and the byte-consuming logic.

Parameters:
- BIT_CYCLES, 4: clock cycles per serial bit period; legal values are >= 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- data_out  output  8  decoded byte; valid while out_valid is 1.
- out_valid  output  1  byte available.
- out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both 1.
- err_corrected  output  1  one-cycle pulse, aligned with out_valid rising, when a single-bit error was corrected.
- err_uncorr  output  1  one-cycle pulse when the syndrome is 13..15; the frame is dropped.
- err_frame  output  1  one-cycle pulse when the stop bit is sampled 0; the frame is dropped.
- overrun  output  1  one-cycle pulse when a good frame completes while the output is occupied; the new byte is dropped.

Behaviour:
- Reset (rst=0, async): state IDLE, data_out=0, out_valid=0, all pulses 0, counters 0, synchronizer flops set to 1.
- rx passes through a 2-flop synchronizer to give rx_s. All sampling uses rx_s.
- Codeword layout: bit[i-1] = Hamming position i, for i = 1..12.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - Parity p_k is the even parity of all positions whose index has bit k set.
- Serial order: position 1 is transmitted first.
- FSM:
  - IDLE: rx_s=0 while the previous rx_s was 1 → START; bit counter cleared.
  - START: wait BIT_CYCLES/2 (integer division) cycles, then sample. Sample 0 → DATA. Sample 1 → IDLE (false start, no flag).
  - DATA: sample every BIT_CYCLES cycles; shift into a 12-bit register at index = bit count. After the 12th sample → STOP.
  - STOP: sample after BIT_CYCLES cycles, then return to IDLE in the same cycle.
    - Sample 0: err_frame pulse next cycle; frame dropped.
    - Sample 1: decode.
- Decode, combinational on the completed register:
  - Syndrome s = XOR of the indices of all set positions (4 bits).
  - s=0: clean.
  - s=1..12: flip position s, then assert err_corrected.
  - s=13..15: err_uncorr; frame dropped.
- Output latency: data_out and out_valid are registered on the stop-sample edge, so out_valid is high in the following cycle. err_corrected pulses in that same cycle.
- Handshake:
  - out_valid holds, and data_out is stable, until out_ready=1.
  - out_valid falls on the edge where out_valid and out_ready are both 1.
  - out_ready is ignored while out_valid=0.
- Simultaneous events:
  - Good frame completes on the same edge as a handshake: the new byte loads, out_valid stays 1, no overrun.
  - Good frame completes while out_valid=1 and out_ready=0: data_out is unchanged, overrun pulses, and err_corrected is suppressed for the dropped frame.
- Reset asserted mid-frame aborts the frame immediately; no flag is raised.

Optional Feature:
- Macro: HAMMING_SERIAL_RX_STATS_EN.
- Defined:
  - Adds output port corr_count (16 bits), which counts err_corrected pulses.
  - Adds output port drop_count (16 bits), which counts err_uncorr, err_frame and overrun pulses. Two events in the same cycle each count.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then send codeword 12'hA27 with stop=1 and out_ready=1 → one out_valid pulse with data_out=8'hA5; err_corrected=0; err_uncorr=0; err_frame=0.
- Send 12'hA07 (position 6 flipped) → data_out=8'hA5 and err_corrected pulses once with out_valid.
- Send 12'h226 (positions 1 and 12 flipped) → err_uncorr pulses once; out_valid stays 0.
- Send 12'hA27 with stop bit 0 → err_frame pulses; no out_valid. Then a clean frame 12'hA27 → data_out=8'hA5.
- Hold out_ready=0 and send 12'hA27 then the encoding of 8'h3C → data_out stays 8'hA5 and overrun pulses once. Raise out_ready → out_valid falls after one handshake.
- Low glitch on rx shorter than BIT_CYCLES/2 → no frame started, no flags. With HAMMING_SERIAL_RX_STATS_EN defined, run cases 2–5 → corr_count=1 and drop_count=3.

Source files
------------

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(12,8) frame receiver: start bit, 12 codeword bits (position 1 first), stop bit.
// Define HAMMING_SERIAL_RX_STATS_EN to add saturating corr_count / drop_count outputs.
module hamming_serial_rx #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_corrected,
    output logic        err_uncorr,
    output logic        err_frame,
    output logic        overrun
`ifdef HAMMING_SERIAL_RX_STATS_EN
    ,
    output logic [15:0] corr_count,
    output logic [15:0] drop_count
`endif
);

    localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           rx_meta, rx_s, rx_prev;
    logic [CW-1:0]  cyc_cnt;
    logic [3:0]     bit_cnt;
    logic [11:0]    shreg;

    logic [3:0]     syn;
    logic [11:0]    fixed;
    logic [7:0]     dec_byte;
    logic           syn_bad;

    always_comb begin
        syn   = '0;
        fixed = shreg;
        for (int unsigned i = 0; i < 12; i++) begin
            if (shreg[i]) syn = syn ^ 4'(i + 1);
        end
        // A syndrome of 13..15 matches no position, so nothing is flipped.
        for (int unsigned i = 0; i < 12; i++) begin
            if (syn == 4'(i + 1)) fixed[i] = ~shreg[i];
        end
        syn_bad  = (syn >= 4'd13);
        dec_byte = {fixed[11], fixed[10], fixed[9], fixed[8],
                    fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_prev       <= 1'b1;
            state         <= IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            data_out      <= '0;
            out_valid     <= 1'b0;
            err_corrected <= 1'b0;
            err_uncorr    <= 1'b0;
            err_frame     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_meta       <= rx;
            rx_s          <= rx_meta;
            rx_prev       <= rx_s;
            err_corrected <= 1'b0;
            err_uncorr    <= 1'b0;
            err_frame     <= 1'b0;
            overrun       <= 1'b0;

            if (out_valid && out_ready) out_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s && rx_prev) state <= START;
                end
                START: begin
                    if (cyc_cnt == HALF_LAST) begin
                        cyc_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt         <= '0;
                        shreg[bit_cnt]  <= rx_s;
                        bit_cnt         <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd11) state <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        state   <= IDLE;
                        if (!rx_s) begin
                            err_frame <= 1'b1;
                        end else if (syn_bad) begin
                            err_uncorr <= 1'b1;
                        end else if (!out_valid || out_ready) begin
                            // Load wins over a same-edge handshake, keeping out_valid high.
                            data_out      <= dec_byte;
                            out_valid     <= 1'b1;
                            err_corrected <= (syn != 4'd0);
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAMMING_SERIAL_RX_STATS_EN
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc = 2'({1'b0, err_uncorr}) + 2'({1'b0, err_frame}) + 2'({1'b0, overrun});
        drop_sum = {1'b0, drop_count} + 17'(drop_inc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_count <= '0;
            drop_count <= '0;
        end else begin
            if (err_corrected && (corr_count != '1)) corr_count <= corr_count + 1'b1;
            drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: clean, corrected, uncorrectable, framing, overrun,
// glitch and mid-frame reset cases with hand-computed codewords.
module tb_hamming_serial_rx;

    localparam int unsigned BC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       out_ready;
    logic [7:0] data_out;
    logic       out_valid, err_corrected, err_uncorr, err_frame, overrun;
`ifdef HAMMING_SERIAL_RX_STATS_EN
    logic [15:0] corr_count, drop_count;
`endif

    hamming_serial_rx #(.BIT_CYCLES(BC)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err_corrected (err_corrected),
        .err_uncorr    (err_uncorr),
        .err_frame     (err_frame),
        .overrun       (overrun)
`ifdef HAMMING_SERIAL_RX_STATS_EN
        ,
        .corr_count    (corr_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Event counters, sampled on the falling edge while out of reset.
    int unsigned n_vld = 0, n_corr = 0, n_unc = 0, n_frm = 0, n_ovr = 0, n_align = 0;
    int unsigned b_vld, b_corr, b_unc, b_frm, b_ovr, b_align;
    logic [7:0]  cap_data = '0;
    logic        pv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && !pv) begin
                n_vld++;
                cap_data = data_out;
                if (err_corrected) n_align++;
            end
            if (err_corrected) n_corr++;
            if (err_uncorr)    n_unc++;
            if (err_frame)     n_frm++;
            if (overrun)       n_ovr++;
        end
        pv = out_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_vld = n_vld; b_corr = n_corr; b_unc = n_unc;
        b_frm = n_frm; b_ovr = n_ovr; b_align = n_align;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] cw, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 12; i++) send_bit(cw[i]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    initial begin
        rst = 1'b0;
        rx = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(data_out), 32'd0);
        chk("rst_corr",  32'(err_corrected), 32'd0);
        chk("rst_unc",   32'(err_uncorr), 32'd0);
        chk("rst_frm",   32'(err_frame), 32'd0);
        chk("rst_ovr",   32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Clean frame
        mark();
        send_frame(12'hA27, 1'b1);
        chk("c1_vld",  n_vld - b_vld, 1);
        chk("c1_data", 32'(cap_data), 32'hA5);
        chk("c1_corr", n_corr - b_corr, 0);
        chk("c1_unc",  n_unc - b_unc, 0);
        chk("c1_frm",  n_frm - b_frm, 0);

        // Position 6 flipped
        mark();
        send_frame(12'hA07, 1'b1);
        chk("c2_vld",   n_vld - b_vld, 1);
        chk("c2_data",  32'(cap_data), 32'hA5);
        chk("c2_corr",  n_corr - b_corr, 1);
        chk("c2_align", n_align - b_align, 1);

        // Positions 1 and 12 flipped: syndrome 13
        mark();
        send_frame(12'h226, 1'b1);
        chk("c3_unc", n_unc - b_unc, 1);
        chk("c3_vld", n_vld - b_vld, 0);

        // Bad stop bit, then a clean frame
        mark();
        send_frame(12'hA27, 1'b0);
        chk("c4_frm", n_frm - b_frm, 1);
        chk("c4_vld", n_vld - b_vld, 0);
        mark();
        send_frame(12'hA27, 1'b1);
        chk("c4b_vld",  n_vld - b_vld, 1);
        chk("c4b_data", 32'(cap_data), 32'hA5);

        // Overrun: output held while a second good frame (0x3C -> 12'h362) arrives
        out_ready = 1'b0;
        mark();
        send_frame(12'hA27, 1'b1);
        send_frame(12'h362, 1'b1);
        @(negedge clk);
        chk("c5_vld",     n_vld - b_vld, 1);
        chk("c5_ovr",     n_ovr - b_ovr, 1);
        chk("c5_corr",    n_corr - b_corr, 0);
        chk("c5_data",    32'(data_out), 32'hA5);
        chk("c5_holdvld", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("c5_fall", 32'(out_valid), 32'd0);
        repeat (4) @(posedge clk); #1;
        chk("c5_vld_total", n_vld - b_vld, 1);

`ifdef HAMMING_SERIAL_RX_STATS_EN
        chk("corr_count", 32'(corr_count), 32'd1);
        chk("drop_count", 32'(drop_count), 32'd3);
`endif

        // One-cycle low glitch
        mark();
        @(posedge clk); #1;
        rx = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        repeat (70) @(posedge clk); #1;
        chk("gl_vld", n_vld - b_vld, 0);
        chk("gl_flags", (n_corr - b_corr) + (n_unc - b_unc) + (n_frm - b_frm) + (n_ovr - b_ovr), 0);

        // Reset in the middle of a frame
        mark();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        repeat (80) @(posedge clk); #1;
        chk("mr_vld",   n_vld - b_vld, 0);
        chk("mr_flags", (n_corr - b_corr) + (n_unc - b_unc) + (n_frm - b_frm) + (n_ovr - b_ovr), 0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        mark();
        send_frame(12'hA27, 1'b1);
        chk("mr_data", 32'(cap_data), 32'hA5);

        // Second data pattern and a corrected parity position
        mark();
        send_frame(12'h362, 1'b1);
        chk("d3c_data", 32'(cap_data), 32'h3C);
        chk("d3c_corr", n_corr - b_corr, 0);
        mark();
        send_frame(12'hA26, 1'b1);
        chk("p1_data", 32'(cap_data), 32'hA5);
        chk("p1_corr", n_corr - b_corr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
